// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: merges the in-order ALU result path with a
// buffered load-return path into one registered write per cycle.
module gpr_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_reg,
    input  logic [31:0] ld_data,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic [31:0] pend_mask,
    output logic        order_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [4:0]       fifoReg  [DEPTH];
    logic [31:0]      fifoData [DEPTH];
    logic [DEPTH-1:0] entryValid;
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic [CW-1:0]    starveCnt;

    logic empty;
    logic full;
    logic aluHit;
    logic aluWin;
    logic pushEn;
    logic popEn;
    logic orderViol;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign ld_ready  = !full;
    assign alu_stall = (starveCnt >= CW'(STARVE_MAX));

    // A stalled ALU request is dropped; the FIFO owns the port then.
    assign aluHit    = alu_valid && (alu_reg != 5'd0);
    assign aluWin    = aluHit && !alu_stall;
    assign popEn     = !empty && !aluWin;
    assign pushEn    = ld_valid && !full && (ld_reg != 5'd0);
    assign orderViol = alu_valid && (alu_stall || pend_mask[alu_reg]);

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) begin
                pend_mask[fifoReg[i]] = 1'b1;
            end
        end
        if (RegWrite) begin
            pend_mask[WriteReg] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (pushEn) begin
            fifoReg[wrPtr]  <= ld_reg;
            fifoData[wrPtr] <= ld_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
        end else begin
            if (pushEn) begin
                wrPtr             <= wrPtr + AW'(1);
                entryValid[wrPtr] <= 1'b1;
            end
            if (popEn) begin
                rdPtr             <= rdPtr + AW'(1);
                entryValid[rdPtr] <= 1'b0;
            end
            unique case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starveCnt <= '0;
        end else if (empty || popEn) begin
            starveCnt <= '0;
        end else if (starveCnt != CW'(STARVE_MAX)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            order_err <= 1'b0;
        end else begin
            if (orderViol) begin
                order_err <= 1'b1;
            end
            if (aluWin) begin
                RegWrite  <= 1'b1;
                WriteReg  <= alu_reg;
                WriteData <= alu_data;
            end else if (popEn) begin
                RegWrite  <= 1'b1;
                WriteReg  <= fifoReg[rdPtr];
                WriteData <= fifoData[rdPtr];
            end else begin
                RegWrite  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, ALU path, load buffering,
// starvation stall, register-0 suppression and ordering violations.
module tb_gpr_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] pend_mask;
    logic        order_err;

    int nTests = 0;
    int nFail  = 0;

    gpr_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_reg(ld_reg), .ld_data(ld_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .pend_mask(pend_mask), .order_err(order_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_reg    = '0;
        ld_data   = '0;
    endtask

    task automatic doReset();
        idleInputs();
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idleInputs();
        RST_N = 1'b0;
        #2;
        nTests++;
        if ({RegWrite, WriteReg, WriteData} !== 38'd0) begin
            nFail++;
            $display("FAIL reset_write got %b/%0d/%h want 0/0/0",
                     RegWrite, WriteReg, WriteData);
        end
        nTests++;
        if ({alu_stall, order_err, ld_ready} !== 3'b001) begin
            nFail++;
            $display("FAIL reset_flags got stall=%b err=%b rdy=%b want 0 0 1",
                     alu_stall, order_err, ld_ready);
        end
        nTests++;
        if (pend_mask !== 32'd0) begin
            nFail++;
            $display("FAIL reset_pend got %h want 0", pend_mask);
        end
        RST_N = 1'b1;
        tick();
        // Two loads buffered behind ALU traffic, then async reset mid-cycle.
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
        ld_valid = 1'b1; ld_reg = 5'd20; ld_data = 32'h20;
        tick();
        ld_reg = 5'd21; ld_data = 32'h21;
        tick();
        idleInputs();
        nTests++;
        if (pend_mask !== ((32'd1 << 20) | (32'd1 << 21) | (32'd1 << 3))) begin
            nFail++;
            $display("FAIL async_pre_pend got %h want %h", pend_mask,
                     (32'd1 << 20) | (32'd1 << 21) | (32'd1 << 3));
        end
        #3;
        RST_N = 1'b0;
        #1;
        nTests++;
        if ({RegWrite, WriteReg, WriteData} !== 38'd0) begin
            nFail++;
            $display("FAIL async_write got %b/%0d/%h want 0/0/0",
                     RegWrite, WriteReg, WriteData);
        end
        nTests++;
        if (pend_mask !== 32'd0 || ld_ready !== 1'b1) begin
            nFail++;
            $display("FAIL async_pend got %h rdy=%b want 0 rdy=1",
                     pend_mask, ld_ready);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nTests++;
            if (RegWrite !== 1'b0) begin
                nFail++;
                $display("FAIL async_nowrite cyc%0d got reg=%0d want no write",
                         i, WriteReg);
            end
        end
    endtask

    task automatic test_alu_single();
        doReset();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        idleInputs();
        nTests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            nFail++;
            $display("FAIL alu_write got %b/%0d/%h want 1/5/deadbeef",
                     RegWrite, WriteReg, WriteData);
        end
        tick();
        nTests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            nFail++;
            $display("FAIL alu_hold got %b/%0d/%h want 0/5/deadbeef",
                     RegWrite, WriteReg, WriteData);
        end
    endtask

    task automatic test_load_behind_alu();
        doReset();
        alu_valid = 1'b1; alu_reg = 5'd3;
        ld_valid = 1'b1; ld_reg = 5'd7; ld_data = 32'h11;
        for (int i = 0; i < 3; i++) begin
            alu_data = 32'h300 + i;
            tick();
            ld_valid = 1'b0;
            nTests++;
            if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd3, 32'h300 + i}) begin
                nFail++;
                $display("FAIL lba_alu%0d got %b/%0d/%h want 1/3/%h",
                         i, RegWrite, WriteReg, WriteData, 32'h300 + i);
            end
            nTests++;
            if (pend_mask !== ((32'd1 << 7) | (32'd1 << 3))) begin
                nFail++;
                $display("FAIL lba_pend%0d got %h want %h", i, pend_mask,
                         (32'd1 << 7) | (32'd1 << 3));
            end
        end
        idleInputs();
        tick();
        nTests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd7, 32'h11}) begin
            nFail++;
            $display("FAIL lba_load got %b/%0d/%h want 1/7/11",
                     RegWrite, WriteReg, WriteData);
        end
        nTests++;
        if (pend_mask !== (32'd1 << 7)) begin
            nFail++;
            $display("FAIL lba_pend_ld got %h want %h", pend_mask, 32'd1 << 7);
        end
        tick();
        nTests++;
        if (RegWrite !== 1'b0 || pend_mask !== 32'd0) begin
            nFail++;
            $display("FAIL lba_done got we=%b pend=%h want 0 0",
                     RegWrite, pend_mask);
        end
    endtask

    task automatic test_full_starve();
        doReset();
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h3;
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_reg = 5'(10 + i);
            ld_data = 32'hA0 + i;
            tick();
        end
        ld_valid = 1'b0;
        nTests++;
        if (ld_ready !== 1'b0) begin
            nFail++;
            $display("FAIL full_ready got %b want 0", ld_ready);
        end
        for (int i = 5; i <= 8; i++) begin
            tick();
        end
        nTests++;
        if (alu_stall !== 1'b0 || WriteReg !== 5'd3) begin
            nFail++;
            $display("FAIL starve_7 got stall=%b reg=%0d want 0 3",
                     alu_stall, WriteReg);
        end
        tick();
        nTests++;
        if (alu_stall !== 1'b1) begin
            nFail++;
            $display("FAIL starve_8 got stall=%b want 1", alu_stall);
        end
        alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nTests++;
            if ({RegWrite, WriteReg, WriteData} !==
                {1'b1, 5'(10 + i), 32'hA0 + i}) begin
                nFail++;
                $display("FAIL drain%0d got %b/%0d/%h want 1/%0d/%h", i,
                         RegWrite, WriteReg, WriteData, 10 + i, 32'hA0 + i);
            end
            if (i == 0) begin
                nTests++;
                if (alu_stall !== 1'b0 || ld_ready !== 1'b1) begin
                    nFail++;
                    $display("FAIL drain_flags got stall=%b rdy=%b want 0 1",
                             alu_stall, ld_ready);
                end
            end
        end
        tick();
        nTests++;
        if (RegWrite !== 1'b0) begin
            nFail++;
            $display("FAIL drain_end got we=%b want 0", RegWrite);
        end
    endtask

    task automatic test_reg0();
        doReset();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
        ld_valid = 1'b1; ld_reg = 5'd0; ld_data = 32'hEEEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            nTests++;
            if (RegWrite !== 1'b0 || pend_mask !== 32'd0 || ld_ready !== 1'b1) begin
                nFail++;
                $display("FAIL reg0_%0d got we=%b pend=%h rdy=%b want 0 0 1",
                         i, RegWrite, pend_mask, ld_ready);
            end
        end
        idleInputs();
        tick();
        nTests++;
        if (RegWrite !== 1'b0) begin
            nFail++;
            $display("FAIL reg0_empty got we=%b want 0", RegWrite);
        end
        ld_valid = 1'b1; ld_reg = 5'd6; ld_data = 32'h66;
        tick();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h1;
        tick();
        idleInputs();
        nTests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd6, 32'h66}) begin
            nFail++;
            $display("FAIL reg0_pop got %b/%0d/%h want 1/6/66",
                     RegWrite, WriteReg, WriteData);
        end
    endtask

    task automatic test_ordering();
        doReset();
        nTests++;
        if (order_err !== 1'b0) begin
            nFail++;
            $display("FAIL ord_init got %b want 0", order_err);
        end
        ld_valid = 1'b1; ld_reg = 5'd9; ld_data = 32'h99;
        tick();
        idleInputs();
        alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h1234;
        tick();
        idleInputs();
        nTests++;
        if ({RegWrite, WriteReg, WriteData, order_err} !==
            {1'b1, 5'd9, 32'h1234, 1'b1}) begin
            nFail++;
            $display("FAIL ord_alu got %b/%0d/%h err=%b want 1/9/1234 err=1",
                     RegWrite, WriteReg, WriteData, order_err);
        end
        tick();
        nTests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd9, 32'h99}) begin
            nFail++;
            $display("FAIL ord_load got %b/%0d/%h want 1/9/99",
                     RegWrite, WriteReg, WriteData);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        nTests++;
        if (order_err !== 1'b1) begin
            nFail++;
            $display("FAIL ord_sticky got %b want 1", order_err);
        end
        doReset();
        nTests++;
        if (order_err !== 1'b0) begin
            nFail++;
            $display("FAIL ord_clear got %b want 0", order_err);
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_load_behind_alu();
        test_full_starve();
        test_reg0();
        test_ordering();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Writer side of the general-purpose register file's single write port.
- Merges two result sources into one write per cycle: the in-order ALU result path, and the variable-latency load-return path, which is buffered in a small FIFO.
- Drives RegWrite/WriteReg/WriteData from registers updated on posedge CLK. The register file samples them on the following negedge, so each write lands half a cycle after it is driven.
- Exports a pending-write mask for the issue stage's hazard stall.

Parameters:
- DEPTH, 4, load-return FIFO entries (power of two, ≥2).
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may go unserved before the ALU path is stalled.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; never back-pressured except via alu_stall.
- alu_reg  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  upstream must hold alu_valid low while high.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted when ld_valid && ld_ready.
- ld_reg  in  5  load destination register.
- ld_data  in  32  load data.
- RegWrite  out  1  write enable to register file.
- WriteReg  out  5  write address.
- WriteData  out  32  write data.
- pend_mask  out  32  bit r set when a write to r is buffered or currently driven.
- order_err  out  1  sticky protocol-violation flag.

Behaviour:
- **Reset (RST_N low, async):**
  - FIFO emptied.
  - Starvation counter = 0.
  - RegWrite = 0, WriteReg = 0, WriteData = 0.
  - alu_stall = 0, order_err = 0, pend_mask = 0, ld_ready = 1.
  - If reset occurs mid-operation, buffered results are discarded with no partial write.
- **FIFO push:** on posedge when ld_valid && ld_ready. ld_ready = !full, combinational from the occupancy count.
  - No push while full, even if a pop occurs in the same cycle.
  - ld_reg == 0 is accepted but not stored.
- **Output register selection, evaluated each posedge, in priority order:**
  1. alu_valid && alu_reg != 0 → RegWrite=1, WriteReg=alu_reg, WriteData=alu_data.
  2. Else FIFO non-empty → pop head; RegWrite=1 with head reg/data.
  3. Else RegWrite=0. WriteReg/WriteData hold their previous values.
  - alu_valid with alu_reg == 0 → no write. The FIFO may pop in that cycle.
- **Latency:**
  - ALU: sample at edge k → RegWrite high in cycle k+1; register file updated at negedge of cycle k+1.
  - Load: push at edge k → earliest pop at edge k+1 → written in cycle k+2.
- **Simultaneous events:**
  - Push and pop in the same edge are legal when not full; occupancy is unchanged.
  - Push into an empty FIFO is not bypassed.
- **Starvation counter:**
  - Increments on each edge where the FIFO is non-empty and not popped.
  - Clears on any pop or when the FIFO is empty.
  - alu_stall = 1 while counter ≥ STARVE_MAX (registered).
  - While alu_stall is high, the FIFO has priority. alu_valid asserted under stall is ignored and sets order_err.
  - The counter saturates and does not wrap.
- **pend_mask (combinational):**
  - OR of onehot(reg) over all valid FIFO entries, plus onehot(WriteReg) if RegWrite.
  - Bit 0 is always 0.
- **Ordering rule:**
  - The issue stage must not send alu_valid for a register set in pend_mask.
  - If it does, the write still proceeds in priority order and order_err sets.
  - order_err clears only on reset.
- **FIFO pointers:** wrap modulo DEPTH. Occupancy is tracked with a log2(DEPTH)+1-bit count so full and empty are distinguishable.

Test Plan:
1. **Reset values and async clear.** Deassert RST_N; assert it mid-cycle while the FIFO holds 2 entries → all outputs are 0 immediately, ld_ready=1, and no later write of those entries occurs.
2. **ALU single write.** alu_valid, reg 5, data 0xDEADBEEF at edge k → RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF in cycle k+1; RegWrite=0 in cycle k+2.
3. **Load behind ALU traffic.** Push load r7=0x11 while the ALU writes r3 for 3 consecutive cycles → r3 is written 3 times, then r7=0x11. pend_mask bit7 is set from edge k+1 until r7's write cycle ends.
4. **Full FIFO and ALU starvation.** With DEPTH=4, push 4 loads during continuous ALU traffic → ld_ready=0 after the 4th push. alu_stall rises after 8 unserved edges; the FIFO then drains in order and alu_stall drops.
5. **Register 0 suppression.** alu_reg=0 and ld_reg=0 → RegWrite never asserts, pend_mask stays 0, and the FIFO count is unchanged.
6. **Ordering violation.** Load r9 is buffered, then alu_valid for r9 → order_err=1 and stays high until reset; the ALU write occurs before the load write.
